// File: rtl/assoc_wb_cache.sv
`default_nettype none
// ============================================================================
// Module      : assoc_wb_cache
// Description : N-way set-associative write-back/write-allocate cache with a
//               line-wide memory port, round-robin replacement and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module assoc_wb_cache #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int SET_BITS  = 6,
  parameter int WAY_BITS  = 2,
  parameter int WORD_BITS = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic                               req_write,
  input  logic [ADDR_BITS-1:0]               req_addr,
  input  logic [DATA_BITS-1:0]               req_wdata,
  output logic                               resp_valid,
  output logic [DATA_BITS-1:0]               resp_rdata,
  output logic                               resp_miss,
  input  logic                               flush_req,
  output logic                               flush_done,
  output logic [ADDR_BITS-1:0]               mem_addr,
  output logic                               mem_read_en,
  output logic                               mem_write_en,
  output logic [DATA_BITS*(2**WORD_BITS)-1:0] mem_wdata,
  input  logic                               mem_ready,
  input  logic                               mem_rvalid,
  input  logic [DATA_BITS*(2**WORD_BITS)-1:0] mem_rdata
);
  localparam int WORDS    = 2**WORD_BITS;
  localparam int SETS     = 2**SET_BITS;
  localparam int WAYS     = 2**WAY_BITS;
  localparam int TAG_BITS = ADDR_BITS - SET_BITS - WORD_BITS;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOOKUP    = 3'd1;
  localparam logic [2:0] S_WRITEBACK = 3'd2;
  localparam logic [2:0] S_REFILL    = 3'd3;
  localparam logic [2:0] S_FLUSH     = 3'd4;

  logic [2:0]                          r_state;
  logic                                r_write;
  logic [TAG_BITS-1:0]                 r_tag;
  logic [SET_BITS-1:0]                 r_set;
  logic [WORD_BITS-1:0]                r_off;
  logic [DATA_BITS-1:0]                r_wdata;
  logic [WAY_BITS-1:0]                 r_victim;
  logic [SET_BITS-1:0]                 r_flush_set;
  logic [WAY_BITS-1:0]                 r_flush_way;
  logic                                r_resp_valid;
  logic                                r_resp_miss;
  logic [DATA_BITS-1:0]                r_resp_rdata;
  logic                                r_flush_done;

  logic [WAYS-1:0]                     r_valid    [SETS];
  logic [WAYS-1:0]                     r_dirty    [SETS];
  logic [WAY_BITS-1:0]                 r_rr       [SETS];
  logic [TAG_BITS-1:0]                 r_tag_mem  [SETS][WAYS];
  logic [WORDS-1:0][DATA_BITS-1:0]     r_data_mem [SETS][WAYS];

  logic                                w_hit;
  logic [WAY_BITS-1:0]                 w_hit_way;
  logic                                w_has_invalid;
  logic [WAY_BITS-1:0]                 w_victim;
  logic                                w_fl_dirty;
  logic                                w_fl_last;
  logic [WORDS-1:0][DATA_BITS-1:0]     w_hit_line;
  logic [WORDS-1:0][DATA_BITS-1:0]     w_fill_line;

  // Tag match and victim choice: first invalid way wins, otherwise round-robin.
  always_comb begin
    w_hit         = 1'b0;
    w_hit_way     = '0;
    w_has_invalid = 1'b0;
    w_victim      = r_rr[r_set];
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[r_set][w] && (r_tag_mem[r_set][w] == r_tag) && !w_hit) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_BITS'(w);
      end
      if (!r_valid[r_set][w] && !w_has_invalid) begin
        w_has_invalid = 1'b1;
        w_victim      = WAY_BITS'(w);
      end
    end
  end

  assign w_hit_line = r_data_mem[r_set][w_hit_way];
  assign w_fl_dirty = r_valid[r_flush_set][r_flush_way] & r_dirty[r_flush_set][r_flush_way];
  assign w_fl_last  = (&r_flush_set) && (&r_flush_way);

  always_comb begin
    w_fill_line = mem_rdata;
    if (r_write) w_fill_line[r_off] = r_wdata;
  end

  assign req_ready    = (r_state == S_IDLE) && !reset;
  assign mem_read_en  = (r_state == S_REFILL);
  assign mem_write_en = (r_state == S_WRITEBACK) || ((r_state == S_FLUSH) && w_fl_dirty);
  assign resp_valid   = r_resp_valid;
  assign resp_miss    = r_resp_miss;
  assign resp_rdata   = r_resp_rdata;
  assign flush_done   = r_flush_done;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      S_WRITEBACK: begin
        mem_addr  = {r_tag_mem[r_set][r_victim], r_set, {WORD_BITS{1'b0}}};
        mem_wdata = r_data_mem[r_set][r_victim];
      end
      S_REFILL: mem_addr = {r_tag, r_set, {WORD_BITS{1'b0}}};
      S_FLUSH: begin
        if (w_fl_dirty) begin
          mem_addr  = {r_tag_mem[r_flush_set][r_flush_way], r_flush_set, {WORD_BITS{1'b0}}};
          mem_wdata = r_data_mem[r_flush_set][r_flush_way];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_resp_valid <= 1'b0;
      r_resp_miss  <= 1'b0;
      r_resp_rdata <= '0;
      r_flush_done <= 1'b0;
      r_flush_set  <= '0;
      r_flush_way  <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        r_rr[s]    <= '0;
      end
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_miss  <= 1'b0;
      r_flush_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (flush_req) begin
            r_flush_set <= '0;
            r_flush_way <= '0;
            r_state     <= S_FLUSH;
          end else if (req_valid) begin
            r_write <= req_write;
            r_tag   <= req_addr[ADDR_BITS-1 -: TAG_BITS];
            r_set   <= req_addr[WORD_BITS +: SET_BITS];
            r_off   <= req_addr[WORD_BITS-1:0];
            r_wdata <= req_wdata;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= r_write ? r_wdata : w_hit_line[r_off];
            if (r_write) r_dirty[r_set][w_hit_way] <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_victim <= w_victim;
            if (!w_has_invalid) r_rr[r_set] <= r_rr[r_set] + 1'b1;
            r_state <= (r_valid[r_set][w_victim] && r_dirty[r_set][w_victim]) ? S_WRITEBACK : S_REFILL;
          end
        end
        S_WRITEBACK: if (mem_ready) r_state <= S_REFILL;
        S_REFILL: begin
          if (mem_rvalid) begin
            r_valid[r_set][r_victim] <= 1'b1;
            r_dirty[r_set][r_victim] <= r_write;
            r_resp_valid <= 1'b1;
            r_resp_miss  <= 1'b1;
            r_resp_rdata <= w_fill_line[r_off];
            r_state      <= S_IDLE;
          end
        end
        S_FLUSH: begin
          // Clean entries advance immediately; dirty ones wait for the memory.
          if (!w_fl_dirty || mem_ready) begin
            if (w_fl_dirty) r_dirty[r_flush_set][r_flush_way] <= 1'b0;
            if (w_fl_last) begin
              r_flush_done <= 1'b1;
              r_state      <= S_IDLE;
            end else begin
              r_flush_way <= r_flush_way + 1'b1;
              if (&r_flush_way) r_flush_set <= r_flush_set + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if ((r_state == S_LOOKUP) && w_hit && r_write)
        r_data_mem[r_set][w_hit_way][r_off] <= r_wdata;
      if ((r_state == S_REFILL) && mem_rvalid) begin
        r_data_mem[r_set][r_victim] <= w_fill_line;
        r_tag_mem[r_set][r_victim]  <= r_tag;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_assoc_wb_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_assoc_wb_cache
// Description : Directed and random checks of assoc_wb_cache against a
//               line-residency model and a flat architectural memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_assoc_wb_cache;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [31:0]  req_addr = '0, req_wdata = '0;
  logic         resp_valid, resp_miss;
  logic [31:0]  resp_rdata;
  logic         flush_req = 1'b0, flush_done;
  logic [31:0]  mem_addr;
  logic         mem_read_en, mem_write_en;
  logic [127:0] mem_wdata;
  logic         mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [127:0] mem_rdata = '0;

  assoc_wb_cache dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_miss(resp_miss),
    .flush_req(flush_req), .flush_done(flush_done),
    .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [127:0] data;
  } txn_t;

  txn_t act_log[$];
  txn_t exp_log[$];

  logic [31:0] mem_store [logic [31:0]];
  logic [31:0] gold      [logic [31:0]];

  bit          m_valid [64][4];
  bit          m_dirty [64][4];
  logic [23:0] m_tag   [64][4];
  int          m_rr    [64];

  int force_delay = -1;
  bit hold_read   = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return mem_store.exists(a) ? mem_store[a] : a + 32'd1;
  endfunction

  function automatic logic [31:0] gold_word(input logic [31:0] a);
    return gold.exists(a) ? gold[a] : a + 32'd1;
  endfunction

  function automatic logic [127:0] gold_line(input logic [31:0] base);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = gold_word(base + 32'(i));
    return l;
  endfunction

  function automatic void exp_push(input bit wr, input logic [31:0] base);
    txn_t t;
    t.wr   = wr;
    t.addr = base;
    t.data = wr ? gold_line(base) : 128'd0;
    exp_log.push_back(t);
  endfunction

  // A dirty line's content is by definition the latest architectural data.
  function automatic void model_access(input bit wr, input logic [31:0] a,
                                       input logic [31:0] d, output bit miss);
    int s = int'(a[7:2]);
    logic [23:0] t = a[31:8];
    int hw = -1;
    int v = -1;
    for (int w = 0; w < 4; w++)
      if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
    if (hw >= 0) begin
      miss = 1'b0;
      if (wr) m_dirty[s][hw] = 1'b1;
    end else begin
      miss = 1'b1;
      for (int w = 3; w >= 0; w--) if (!m_valid[s][w]) v = w;
      if (v < 0) begin
        v = m_rr[s];
        m_rr[s] = (m_rr[s] + 1) % 4;
      end
      if (m_valid[s][v] && m_dirty[s][v]) exp_push(1'b1, {m_tag[s][v], 6'(s), 2'b00});
      exp_push(1'b0, {t, 6'(s), 2'b00});
      m_valid[s][v] = 1'b1;
      m_tag[s][v]   = t;
      m_dirty[s][v] = wr;
    end
    if (wr) gold[a] = d;
  endfunction

  function automatic void model_flush();
    for (int s = 0; s < 64; s++)
      for (int w = 0; w < 4; w++)
        if (m_valid[s][w] && m_dirty[s][w]) begin
          exp_push(1'b1, {m_tag[s][w], 6'(s), 2'b00});
          m_dirty[s][w] = 1'b0;
        end
  endfunction

  // Dirty data not yet written back is lost on reset.
  function automatic void model_reset();
    for (int s = 0; s < 64; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < 4; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
    end
    gold.delete();
    foreach (mem_store[k]) gold[k] = mem_store[k];
  endfunction

  // Memory responder with programmable latency.
  bit           busy = 1'b0;
  int           cnt = 0;
  logic [31:0]  cur_addr;
  logic [127:0] cur_data;

  always @(negedge clk) begin
    txn_t t;
    mem_rvalid = 1'b0;
    mem_ready  = 1'b0;
    if (reset) begin
      busy = 1'b0;
    end else if (mem_read_en || mem_write_en) begin
      check_eq("exclusive_en", 128'(mem_read_en & mem_write_en), 128'd0);
      if (!busy) begin
        busy     = 1'b1;
        cur_addr = mem_addr;
        cur_data = mem_write_en ? mem_wdata : 128'd0;
        cnt      = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
        t.wr = mem_write_en; t.addr = cur_addr; t.data = cur_data;
        act_log.push_back(t);
      end else begin
        check_eq("mem_addr_stable", 128'(mem_addr), 128'(cur_addr));
        if (mem_write_en) check_eq("mem_wdata_stable", mem_wdata, cur_data);
      end
      if (mem_write_en) begin
        check_eq("wb_req_ready", 128'(req_ready), 128'd0);
        check_eq("wb_resp_valid", 128'(resp_valid), 128'd0);
      end
      if (cnt > 0) cnt--;
      else if (mem_write_en) begin
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) mem_store[cur_addr + 32'(i)] = cur_data[i*32 +: 32];
        busy = 1'b0;
      end else if (!hold_read) begin
        mem_rvalid = 1'b1;
        for (int i = 0; i < 4; i++) mem_rdata[i*32 +: 32] = mem_word(cur_addr + 32'(i));
        busy = 1'b0;
      end
    end else begin
      busy = 1'b0;
    end
  end

  bit prev_resp = 1'b0, prev_done = 1'b0;
  always @(negedge clk) begin
    if (!reset && resp_valid) check_eq("resp_pulse", 128'(prev_resp), 128'd0);
    if (!reset && flush_done) check_eq("done_pulse", 128'(prev_done), 128'd0);
    prev_resp = resp_valid;
    prev_done = flush_done;
  end

  task automatic compare_logs(input string tag);
    check_eq({tag, "_txn_count"}, 128'(act_log.size()), 128'(exp_log.size()));
    for (int i = 0; i < act_log.size() && i < exp_log.size(); i++) begin
      check_eq({tag, "_txn_kind"}, 128'(act_log[i].wr), 128'(exp_log[i].wr));
      check_eq({tag, "_txn_addr"}, 128'(act_log[i].addr), 128'(exp_log[i].addr));
      check_eq({tag, "_txn_data"}, act_log[i].data, exp_log[i].data);
    end
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!req_ready && w < 100) begin @(negedge clk); w++; end
    check_eq("ready_timeout", 128'(req_ready), 128'd1);
  endtask

  task automatic do_req(input string tag, input bit wr, input logic [31:0] a,
                        input logic [31:0] d);
    bit exp_miss;
    logic [31:0] exp_rd;
    int cyc;
    act_log.delete();
    exp_log.delete();
    model_access(wr, a, d, exp_miss);
    exp_rd = wr ? d : gold_word(a);
    wait_ready();
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (!resp_valid && cyc < 500) begin @(negedge clk); cyc++; end
    check_eq({tag, "_resp_valid"}, 128'(resp_valid), 128'd1);
    check_eq({tag, "_miss"}, 128'(resp_miss), 128'(exp_miss));
    check_eq({tag, "_rdata"}, 128'(resp_rdata), 128'(exp_rd));
    if (!exp_miss) check_eq({tag, "_hit_latency"}, 128'(cyc), 128'd2);
    compare_logs(tag);
  endtask

  task automatic do_flush(input string tag, output int nwr);
    int cyc;
    act_log.delete();
    exp_log.delete();
    model_flush();
    wait_ready();
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    cyc = 1;
    while (!flush_done && cyc < 3000) begin @(negedge clk); cyc++; end
    check_eq({tag, "_done"}, 128'(flush_done), 128'd1);
    compare_logs(tag);
    nwr = act_log.size();
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = 1'b0; flush_req = 1'b0;
    @(negedge clk);
    check_eq("rst_ready_low", 128'(req_ready), 128'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    act_log.delete();
    check_eq("rst_ready", 128'(req_ready), 128'd1);
    check_eq("rst_resp_valid", 128'(resp_valid), 128'd0);
    check_eq("rst_resp_miss", 128'(resp_miss), 128'd0);
    check_eq("rst_flush_done", 128'(flush_done), 128'd0);
    check_eq("rst_mem_en", 128'({mem_read_en, mem_write_en}), 128'd0);
    check_eq("rst_mem_addr", 128'(mem_addr), 128'd0);
  endtask

  initial begin
    int n;
    int w;
    @(negedge clk);
    do_reset();

    do_req("cold_rd", 1'b0, 32'h0, 32'h0);
    do_req("hit_rd3", 1'b0, 32'h3, 32'h0);
    check_eq("hit_rd3_value", 128'(resp_rdata), 128'd4);
    do_req("hit_wr2", 1'b1, 32'h2, 32'h55);
    do_req("hit_rd2", 1'b0, 32'h2, 32'h0);

    do_reset();
    for (int i = 1; i <= 4; i++) do_req("fill45", 1'b1, 32'(i * 32'h100), 32'd45);
    force_delay = 5;
    do_req("evict_500", 1'b0, 32'h500, 32'h0);
    force_delay = -1;
    if (act_log.size() > 0) begin
      check_eq("evict_wb_addr", 128'(act_log[0].addr), 128'h100);
      check_eq("evict_wb_word0", 128'(act_log[0].data[31:0]), 128'd45);
    end
    do_flush("flush1", n);
    check_eq("flush1_writes", 128'(n), 128'd3);
    do_req("post_flush_rd", 1'b0, 32'h200, 32'h0);
    do_flush("flush2", n);
    check_eq("flush2_writes", 128'(n), 128'd0);

    // Abandon a refill by reset; the memory is told never to answer it.
    hold_read = 1'b1;
    wait_ready();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0;
    @(negedge clk);
    req_valid = 1'b0;
    w = 0;
    while (!mem_read_en && w < 100) begin @(negedge clk); w++; end
    check_eq("rst_refill_seen", 128'(mem_read_en), 128'd1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_refill_rd_en", 128'(mem_read_en), 128'd0);
    check_eq("rst_refill_resp", 128'(resp_valid), 128'd0);
    reset = 1'b0;
    hold_read = 1'b0;
    model_reset();
    @(negedge clk);
    check_eq("rst_refill_idle_resp", 128'(resp_valid), 128'd0);
    do_req("after_rst_rd", 1'b0, 32'h0, 32'h0);

    for (int k = 0; k < 300; k++) begin
      int r = int'($urandom_range(0, 99));
      logic [31:0] a = (32'($urandom_range(0, 7)) << 8) | (32'($urandom_range(0, 1)) << 2)
                       | 32'($urandom_range(0, 3));
      if (r < 4) do_flush("rnd_flush", n);
      else do_req("rnd", r < 50, a, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
